// File: rtl/gf_event_merger.sv
// gf_event_merger
//   Merges the word streams of N_CH formatter channels into one output FIFO,
//   one event at a time. Channels are drained in fixed order ch0..ch(N_CH-1),
//   each through its end-event (EE) word. Only the last channel's EE word is
//   forwarded, so downstream sees exactly one merged event per EE.
//
//   Word format: {ee[W-1], ep[W-2], data[W-3:0]}
//
//   Optional feature macro: GF_MERGE_TAG_CHECK_EN
//     When defined, data[7:0] of ch0's EE is stored as the event tag. Every
//     later channel's EE tag is compared against it. A mismatch sets the sticky
//     err_o and marks the forwarded final EE with data[20]=1.
//     When undefined, err_o is tied 0 and the final EE is forwarded unmodified.
//
// Ports
//   clock_i     system clock, rising edge
//   reset_ni    synchronous active-low reset
//   in_data_i   channel words, ch k on [k*W +: W], first-word-fall-through
//   in_empty_i  channel FIFO empty flags
//   in_re_o     channel pop strobes (one-hot or zero)
//   out_o       merged word (registered)
//   out_we_o    write strobe for out_o
//   out_full_i  output FIFO programmable-full (>=2 free slots when asserted)
//   cur_ch_o    channel currently being drained
//   busy_o      high from the first pop of an event until its merged EE is written
//   evt_cnt_o   completed merged events, wraps
//   err_o       sticky EE tag mismatch flag
module gf_event_merger #(
    parameter int N_CH  = 4,
    parameter int W     = 23,
    parameter int CNT_W = 16
) (
    input  logic                clock_i,
    input  logic                reset_ni,
    input  logic [N_CH*W-1:0]   in_data_i,
    input  logic [N_CH-1:0]     in_empty_i,
    output logic [N_CH-1:0]     in_re_o,
    output logic [W-1:0]        out_o,
    output logic                out_we_o,
    input  logic                out_full_i,
    output logic [2:0]          cur_ch_o,
    output logic                busy_o,
    output logic [CNT_W-1:0]    evt_cnt_o,
    output logic                err_o
);

    localparam int          EE_BIT  = W - 1;
    localparam logic [2:0]  LAST_CH = 3'(N_CH - 1);

    logic [2:0]       cur_ch_q, cur_ch_d;
    logic [W-1:0]     out_q, out_d;
    logic             out_we_q, out_we_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d;

    logic [W-1:0]     head;
    logic             head_empty;
    logic             head_ee;
    logic             at_last;
    logic             pop;
    logic [W-1:0]     fwd_word;

    // Select the head word and empty flag of the current channel.
    always_comb begin
        head       = '0;
        head_empty = 1'b1;
        for (int k = 0; k < N_CH; k++) begin
            if (cur_ch_q == 3'(k)) begin
                head       = in_data_i[k*W +: W];
                head_empty = in_empty_i[k];
            end
        end
    end

    assign head_ee = head[EE_BIT];
    assign at_last = (cur_ch_q == LAST_CH);
    // Gated by reset so nothing is popped (and lost) while held in reset.
    assign pop     = reset_ni && !head_empty && !out_full_i;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_re
            assign in_re_o[gi] = pop && (cur_ch_q == 3'(gi));
        end
    endgenerate

`ifdef GF_MERGE_TAG_CHECK_EN
    logic [7:0] tag_q, tag_d;
    logic       evt_err_q, evt_err_d;   // mismatch seen within the current event
    logic       err_q, err_d;
    logic       tag_miss;

    always_comb begin
        tag_d     = tag_q;
        evt_err_d = evt_err_q;
        err_d     = err_q;
        fwd_word  = head;
        tag_miss  = (head[7:0] != tag_q);
        if (pop && head_ee) begin
            if (cur_ch_q == 3'd0) begin
                tag_d     = head[7:0];
                evt_err_d = 1'b0;
            end else if (tag_miss) begin
                evt_err_d = 1'b1;
                err_d     = 1'b1;
            end
        end
        // Only the final EE is marked; ch0 is never the last channel.
        if (head_ee && at_last && (evt_err_q || tag_miss)) begin
            fwd_word[20] = 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            tag_q     <= '0;
            evt_err_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            tag_q     <= tag_d;
            evt_err_q <= evt_err_d;
            err_q     <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign fwd_word = head;
    assign err_o    = 1'b0;
`endif

    always_comb begin
        cur_ch_d  = cur_ch_q;
        out_d     = out_q;
        out_we_d  = 1'b0;
        busy_d    = busy_q;
        evt_cnt_d = evt_cnt_q;
        if (pop) begin
            busy_d = 1'b1;
            if (!head_ee) begin
                out_d    = head;
                out_we_d = 1'b1;
            end else if (at_last) begin
                // Merged EE: write it, close the event, restart at ch0.
                out_d     = fwd_word;
                out_we_d  = 1'b1;
                cur_ch_d  = 3'd0;
                evt_cnt_d = evt_cnt_q + 1'b1;
                busy_d    = 1'b0;
            end else begin
                // Intermediate EE is swallowed; move to the next channel.
                cur_ch_d = cur_ch_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            cur_ch_q  <= '0;
            out_q     <= '0;
            out_we_q  <= 1'b0;
            busy_q    <= 1'b0;
            evt_cnt_q <= '0;
        end else begin
            cur_ch_q  <= cur_ch_d;
            out_q     <= out_d;
            out_we_q  <= out_we_d;
            busy_q    <= busy_d;
            evt_cnt_q <= evt_cnt_d;
        end
    end

    assign out_o     = out_q;
    assign out_we_o  = out_we_q;
    assign cur_ch_o  = cur_ch_q;
    assign busy_o    = busy_q;
    assign evt_cnt_o = evt_cnt_q;

endmodule

// File: tb/tb_gf_event_merger.sv
// tb_gf_event_merger
//   Directed bench for gf_event_merger (N_CH=4, W=23). Channel FIFOs are
//   modelled as queues presenting first-word-fall-through heads. A second
//   instance with an 8-bit event counter shares all inputs so counter wrap
//   can be reached in a short run.
module tb_gf_event_merger;

    localparam int N_CH = 4;
    localparam int W    = 23;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N_CH*W-1:0] in_data;
    logic [N_CH-1:0]   in_empty;
    logic [N_CH-1:0]   in_re;
    logic [N_CH-1:0]   in_re_w;
    logic [W-1:0]      out_w, out_w2;
    logic              out_we, out_we2;
    logic              out_full;
    logic [2:0]        cur_ch, cur_ch2;
    logic              busy, busy2;
    logic [15:0]       evt_cnt;
    logic [7:0]        evt_cnt2;
    logic              err, err2;

    always #5 clk = ~clk;

    gf_event_merger #(.N_CH(N_CH), .W(W), .CNT_W(16)) dut (
        .clock_i(clk), .reset_ni(rst_n), .in_data_i(in_data), .in_empty_i(in_empty),
        .in_re_o(in_re), .out_o(out_w), .out_we_o(out_we), .out_full_i(out_full),
        .cur_ch_o(cur_ch), .busy_o(busy), .evt_cnt_o(evt_cnt), .err_o(err)
    );

    gf_event_merger #(.N_CH(N_CH), .W(W), .CNT_W(8)) dut_w (
        .clock_i(clk), .reset_ni(rst_n), .in_data_i(in_data), .in_empty_i(in_empty),
        .in_re_o(in_re_w), .out_o(out_w2), .out_we_o(out_we2), .out_full_i(out_full),
        .cur_ch_o(cur_ch2), .busy_o(busy2), .evt_cnt_o(evt_cnt2), .err_o(err2)
    );

    logic [W-1:0] q0[$], q1[$], q2[$], q3[$];
    logic [W-1:0] got_q[$];
    logic [N_CH-1:0] re_s;
    int pop_cnt[N_CH];
    int tests = 0;
    int fails = 0;

    function automatic logic [W-1:0] dw(int k, int i);
        return {2'b00, 21'(k*16 + i)};
    endfunction

    function automatic logic [W-1:0] ee(int tag);
        return {2'b10, 21'(tag)};
    endfunction

    task automatic refresh();
        in_data[0*W +: W] = (q0.size() > 0) ? q0[0] : '0;
        in_data[1*W +: W] = (q1.size() > 0) ? q1[0] : '0;
        in_data[2*W +: W] = (q2.size() > 0) ? q2[0] : '0;
        in_data[3*W +: W] = (q3.size() > 0) ? q3[0] : '0;
        in_empty = {q3.size() == 0, q2.size() == 0, q1.size() == 0, q0.size() == 0};
    endtask

    task automatic push(int ch, logic [W-1:0] word);
        case (ch)
            0: q0.push_back(word);
            1: q1.push_back(word);
            2: q2.push_back(word);
            default: q3.push_back(word);
        endcase
        refresh();
    endtask

    // One clock: sample pop strobes mid-cycle, then model the FIFO pops at the edge.
    task automatic step();
        @(negedge clk);
        re_s = in_re;
        @(posedge clk);
        #1;
        if (re_s[0]) begin void'(q0.pop_front()); pop_cnt[0]++; end
        if (re_s[1]) begin void'(q1.pop_front()); pop_cnt[1]++; end
        if (re_s[2]) begin void'(q2.pop_front()); pop_cnt[2]++; end
        if (re_s[3]) begin void'(q3.pop_front()); pop_cnt[3]++; end
        refresh();
        if (out_we) got_q.push_back(out_w);
    endtask

    task automatic run_until_ee(int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (got_q.size() > 0 && got_q[got_q.size()-1][W-1]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_full = 1'b0;
        refresh();
        for (int i = 0; i < 3; i++) step();
        tests++;
        if ({out_w, out_we, cur_ch, busy, evt_cnt, err, re_s} !== '0) begin
            fails++;
            $display("FAIL reset_state got out=%h we=%b ch=%0d busy=%b cnt=%h err=%b re=%b required all 0",
                     out_w, out_we, cur_ch, busy, evt_cnt, err, re_s);
        end
        rst_n = 1'b1;
        step();
        tests++;
        if (out_we !== 1'b0 || busy !== 1'b0 || got_q.size() != 0) begin
            fails++;
            $display("FAIL reset_idle got we=%b busy=%b writes=%0d required 0 0 0", out_we, busy, got_q.size());
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_basic();
        bit ok;
        logic [W-1:0] exp;
        got_q.delete();
        for (int k = 0; k < N_CH; k++) begin
            push(k, dw(k, 0));
            push(k, dw(k, 1));
            push(k, ee(5));
        end
        step();
        tests++;
        if (out_we !== 1'b1 || out_w !== dw(0, 0) || busy !== 1'b1) begin
            fails++;
            $display("FAIL basic_latency got we=%b out=%h busy=%b required 1 %h 1", out_we, out_w, busy, dw(0, 0));
        end
        run_until_ee(40, ok);
        tests++;
        if (!ok || got_q.size() != 9) begin
            fails++;
            $display("FAIL basic_count got ok=%b writes=%0d required 1 9", ok, got_q.size());
        end
        for (int j = 0; j < 9 && j < got_q.size(); j++) begin
            exp = (j < 8) ? dw(j / 2, j % 2) : ee(5);
            tests++;
            if (got_q[j] !== exp) begin
                fails++;
                $display("FAIL basic_word%0d got %h required %h", j, got_q[j], exp);
            end
        end
        tests++;
        if (evt_cnt !== 16'd1 || cur_ch !== 3'd0 || busy !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL basic_end got cnt=%h ch=%0d busy=%b err=%b required 0001 0 0 0", evt_cnt, cur_ch, busy, err);
        end
        $display("[TB] test_basic done, %0d words", got_q.size());
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [W-1:0] exp;
        got_q.delete();
        for (int k = 0; k < N_CH; k++) begin
            for (int i = 0; i < 3; i++) push(k, dw(k, i));
            push(k, ee(5));
        end
        for (int i = 0; i < 5; i++) step();
        out_full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            tests++;
            if (re_s !== '0 || out_we !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold%0d got re=%b we=%b required 0 0", i, re_s, out_we);
            end
        end
        out_full = 1'b0;
        run_until_ee(40, ok);
        tests++;
        if (!ok || got_q.size() != 13) begin
            fails++;
            $display("FAIL bp_count got ok=%b writes=%0d required 1 13", ok, got_q.size());
        end
        for (int j = 0; j < 13 && j < got_q.size(); j++) begin
            exp = (j < 12) ? dw(j / 3, j % 3) : ee(5);
            tests++;
            if (got_q[j] !== exp) begin
                fails++;
                $display("FAIL bp_word%0d got %h required %h", j, got_q[j], exp);
            end
        end
        tests++;
        if (evt_cnt !== 16'd2) begin
            fails++;
            $display("FAIL bp_cnt got %h required 0002", evt_cnt);
        end
        $display("[TB] test_backpressure done, %0d words", got_q.size());
    endtask

    task automatic test_channel_wait();
        bit ok;
        int p2;
        logic [W-1:0] exp[4];
        got_q.delete();
        push(0, dw(0, 0)); push(0, ee(0));
        push(2, dw(2, 0)); push(2, ee(0));
        push(3, ee(0));
        step(); step();
        tests++;
        if (cur_ch !== 3'd1) begin
            fails++;
            $display("FAIL wait_switch got ch=%0d required 1", cur_ch);
        end
        p2 = pop_cnt[2];
        for (int i = 0; i < 50; i++) begin
            step();
            tests++;
            if (cur_ch !== 3'd1 || out_we !== 1'b0 || re_s !== '0) begin
                fails++;
                $display("FAIL wait_hold%0d got ch=%0d we=%b re=%b required 1 0 0", i, cur_ch, out_we, re_s);
            end
        end
        tests++;
        if (pop_cnt[2] != p2) begin
            fails++;
            $display("FAIL wait_ch2_untouched got pops=%0d required %0d", pop_cnt[2], p2);
        end
        push(1, dw(1, 0)); push(1, ee(0));
        run_until_ee(20, ok);
        exp = '{dw(0, 0), dw(1, 0), dw(2, 0), ee(0)};
        tests++;
        if (!ok || got_q.size() != 4) begin
            fails++;
            $display("FAIL wait_count got ok=%b writes=%0d required 1 4", ok, got_q.size());
        end
        for (int j = 0; j < 4 && j < got_q.size(); j++) begin
            tests++;
            if (got_q[j] !== exp[j]) begin
                fails++;
                $display("FAIL wait_word%0d got %h required %h", j, got_q[j], exp[j]);
            end
        end
        tests++;
        if (evt_cnt !== 16'd3) begin
            fails++;
            $display("FAIL wait_cnt got %h required 0003", evt_cnt);
        end
        $display("[TB] test_channel_wait done");
    endtask

    task automatic test_mid_reset();
        bit ok;
        logic [W-1:0] exp[3];
        got_q.delete();
        for (int i = 0; i < 5; i++) push(0, dw(0, i));
        push(0, ee(0));
        for (int k = 1; k < N_CH; k++) push(k, ee(0));
        step(); step(); step();
        rst_n = 1'b0;
        step();
        tests++;
        if ({out_w, out_we, cur_ch, busy, evt_cnt, err, re_s} !== '0) begin
            fails++;
            $display("FAIL midrst_state got out=%h we=%b ch=%0d busy=%b cnt=%h err=%b re=%b required all 0",
                     out_w, out_we, cur_ch, busy, evt_cnt, err, re_s);
        end
        tests++;
        if (q0.size() != 3) begin
            fails++;
            $display("FAIL midrst_no_pop got ch0 depth=%0d required 3", q0.size());
        end
        rst_n = 1'b1;
        got_q.delete();
        run_until_ee(20, ok);
        exp = '{dw(0, 3), dw(0, 4), ee(0)};
        tests++;
        if (!ok || got_q.size() != 3) begin
            fails++;
            $display("FAIL midrst_count got ok=%b writes=%0d required 1 3", ok, got_q.size());
        end
        for (int j = 0; j < 3 && j < got_q.size(); j++) begin
            tests++;
            if (got_q[j] !== exp[j]) begin
                fails++;
                $display("FAIL midrst_word%0d got %h required %h", j, got_q[j], exp[j]);
            end
        end
        tests++;
        if (evt_cnt !== 16'd1) begin
            fails++;
            $display("FAIL midrst_cnt got %h required 0001", evt_cnt);
        end
        $display("[TB] test_mid_reset done");
    endtask

    task automatic test_wrap();
        int bad;
        got_q.delete();
        for (int n = 0; n < 254; n++) begin
            for (int k = 0; k < N_CH; k++) push(k, ee(0));
        end
        for (int i = 0; i < 254 * N_CH; i++) step();
        tests++;
        if (evt_cnt2 !== 8'hFF || evt_cnt !== 16'h00FF) begin
            fails++;
            $display("FAIL wrap_preload got narrow=%h wide=%h required FF 00FF", evt_cnt2, evt_cnt);
        end
        bad = 0;
        foreach (got_q[j]) if (got_q[j] !== ee(0)) bad++;
        tests++;
        if (got_q.size() != 254 || bad != 0) begin
            fails++;
            $display("FAIL wrap_ee_only got writes=%0d bad=%0d required 254 0", got_q.size(), bad);
        end
        for (int k = 0; k < N_CH; k++) push(k, ee(0));
        for (int i = 0; i < N_CH; i++) step();
        tests++;
        if (evt_cnt2 !== 8'h00 || evt_cnt !== 16'h0100 || cur_ch !== 3'd0) begin
            fails++;
            $display("FAIL wrap_rollover got narrow=%h wide=%h ch=%0d required 00 0100 0", evt_cnt2, evt_cnt, cur_ch);
        end
        $display("[TB] test_wrap done, narrow=%h wide=%h", evt_cnt2, evt_cnt);
    endtask

    task automatic test_tag();
        bit ok;
        logic [W-1:0] exp;
        logic exp_err;
`ifdef GF_MERGE_TAG_CHECK_EN
        exp     = 23'h500011;
        exp_err = 1'b1;
`else
        exp     = 23'h400011;
        exp_err = 1'b0;
`endif
        got_q.delete();
        push(0, ee(8'h11)); push(1, ee(8'h11)); push(2, ee(8'h12)); push(3, ee(8'h11));
        run_until_ee(20, ok);
        tests++;
        if (!ok || got_q.size() != 1 || got_q[0] !== exp) begin
            fails++;
            $display("FAIL tag_word got ok=%b writes=%0d word=%h required 1 1 %h",
                     ok, got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, exp);
        end
        tests++;
        if (err !== exp_err || evt_cnt !== 16'h0101) begin
            fails++;
            $display("FAIL tag_err got err=%b cnt=%h required %b 0101", err, evt_cnt, exp_err);
        end
        $display("[TB] test_tag done");
    endtask

    initial begin
        for (int k = 0; k < N_CH; k++) pop_cnt[k] = 0;
        rst_n    = 1'b0;
        out_full = 1'b0;
        in_data  = '0;
        in_empty = '1;
        test_reset();
        test_basic();
        test_backpressure();
        test_channel_wait();
        test_mid_reset();
        test_wrap();
        test_tag();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
